// File: rtl/softmax_req_scheduler.sv
// rtl/softmax_req_scheduler.sv - round-robin scheduler sharing one softmax_approx engine among NREQ requesters
//
// Accepts one job at a time from NREQ level-held requesters (round-robin),
// latches the winner's vector and length, pulses the engine once, waits for
// its result with a timeout and returns the result on a valid/ready port
// tagged with the requester id.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         per-requester request / one-hot accept (IDLE only)
//   req_len, req_x_flat           per-requester length (8b) and vector (N*16b)
//   sm_valid_in, sm_length_mode   engine start pulse and length mode
//   sm_x_flat                     engine input vector (registered)
//   sm_valid_out, sm_prob_flat    engine result strobe and vector
//   resp_valid / resp_ready       response handshake
//   resp_id, resp_len             served requester and its latched length
//   resp_prob_flat, resp_timeout  result (zeros on timeout) and timeout flag
//   busy, err_count               not-idle flag, saturating timeout count
module softmax_req_scheduler #(
    parameter int N       = 64,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*8-1:0]      req_len,
    input  logic [NREQ*N*16-1:0]   req_x_flat,
    output logic                   sm_valid_in,
    output logic [1:0]             sm_length_mode,
    output logic [N*16-1:0]        sm_x_flat,
    input  logic                   sm_valid_out,
    input  logic [N*16-1:0]        sm_prob_flat,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [7:0]             resp_len,
    output logic [N*16-1:0]        resp_prob_flat,
    output logic                   resp_timeout,
    output logic                   busy,
    output logic [7:0]             err_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Wide enough to hold TIMEOUT with one spare count.
    localparam int             TW       = $clog2(TIMEOUT + 2);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [7:0]      len_arr [NREQ];
    logic [N*16-1:0] x_arr   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign len_arr[g] = req_len[8*g +: 8];
        assign x_arr[g]   = req_x_flat[N*16*g +: N*16];
    end

    // Round-robin search starting just after the last winner, wrapping at NREQ-1.
    always_comb begin
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_grant;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IDW'(1);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Zero or over-long lengths fall back to the full-vector mode.
    function automatic logic [1:0] len_to_mode(input logic [7:0] len);
        if (len == 8'd0 || int'(len) > N) begin
            return 2'd2;
        end else if (len <= 8'd16) begin
            return 2'd0;
        end else if (len <= 8'd32) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // The timer counts the current WAIT cycle, so TIMEOUT WAIT cycles elapse
    // before the abort and the response appears TIMEOUT+1 cycles after the pulse.
    assign timer_next = timer + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            last_grant     <= LAST_IDX;
            timer          <= '0;
            sm_valid_in    <= 1'b0;
            sm_length_mode <= '0;
            sm_x_flat      <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= '0;
            resp_len       <= '0;
            resp_prob_flat <= '0;
            resp_timeout   <= 1'b0;
            busy           <= 1'b0;
            err_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        sm_x_flat      <= x_arr[grant_idx];
                        resp_len       <= len_arr[grant_idx];
                        sm_length_mode <= len_to_mode(len_arr[grant_idx]);
                        resp_id        <= grant_idx;
                        last_grant     <= grant_idx;
                        resp_timeout   <= 1'b0;
                        sm_valid_in    <= 1'b1;
                        busy           <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sm_valid_in <= 1'b0;
                    timer       <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer_next;
                    // An engine result on the timeout cycle still wins.
                    if (sm_valid_out) begin
                        resp_prob_flat <= sm_prob_flat;
                        resp_valid     <= 1'b1;
                        state          <= S_RESP;
                    end else if (timer_next == TW'(TIMEOUT)) begin
                        resp_prob_flat <= '0;
                        resp_timeout   <= 1'b1;
                        resp_valid     <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/softmax_req_scheduler.md
Name: softmax_req_scheduler

Overview:
- Shares one softmax_approx engine between NREQ independent requesters, such as attention heads or a UART front end plus a host DMA port.
- Arbitrates round-robin and latches the winner's vector and length.
- Derives length_mode from the length, pulses the engine, and waits for its result with a timeout.
- Presents the result on a valid/ready response port tagged with the requester id.

Parameters:
- N, 64, vector length in 16-bit words; must match the engine.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, maximum cycles spent waiting for sm_valid_out before aborting.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NREQ  per-requester request pending.
- req_ready  out  NREQ  one-hot accept; asserted combinationally in IDLE for the arbitration winner only.
- req_len  in  NREQ*8  per-requester payload length; slice i is [8*i +: 8].
- req_x_flat  in  NREQ*N*16  per-requester input vector; slice i is [N*16*i +: N*16].
- sm_valid_in  out  1  one-cycle start pulse to the engine.
- sm_length_mode  out  2  engine length_mode.
- sm_x_flat  out  N*16  engine input vector (registered).
- sm_valid_out  in  1  engine result strobe.
- sm_prob_flat  in  N*16  engine result vector.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  index of the served requester.
- resp_len  out  8  raw req_len latched at accept.
- resp_prob_flat  out  N*16  latched result, or all zeros on timeout.
- resp_timeout  out  1  response produced by timeout, not by the engine.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: sm_x_flat, resp_prob_flat, resp_id, resp_len, err_count, sm_length_mode.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has first priority.
- Reset mid-operation returns to IDLE within one edge. No response is produced for the in-flight job. A later sm_valid_out is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[winner] = 1; all other bits are 0.
  - On that edge:
    - latch req_x_flat slice into sm_x_flat;
    - latch req_len into resp_len;
    - latch mode into sm_length_mode;
    - latch winner into resp_id and last_grant;
    - clear resp_timeout;
    - go to ISSUE.
  - With no req_valid, stay in IDLE.
- Length mode:
  - len == 0 or len > N -> 2.
  - len <= 16 -> 0.
  - len <= 32 -> 1.
  - Otherwise -> 2.
- ISSUE: sm_valid_in = 1 for exactly this one cycle. Clear the wait timer to 0. Go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If sm_valid_out: latch sm_prob_flat into resp_prob_flat and go to RESP.
  - Else if timer == TIMEOUT: set resp_prob_flat = 0 and resp_timeout = 1, increment err_count (saturating at 255), and go to RESP.
  - sm_valid_out wins if it coincides with the timeout cycle.
- RESP:
  - resp_valid = 1.
  - resp_id, resp_len, resp_prob_flat and resp_timeout stay stable until the cycle with resp_valid && resp_ready, then go to IDLE.
  - resp_valid drops the following cycle.
- sm_x_flat and sm_length_mode stay stable from ISSUE until the next accept.
- sm_valid_out outside WAIT is ignored.
- req_ready is 0 in every state except IDLE. Requests arriving while busy wait with no loss, since req_valid is level-held by requesters.
- Latency, with accept at edge k:
  - sm_valid_in is high in cycle k+1.
  - resp_valid rises on the edge after sm_valid_out is sampled.
  - Minimum turnaround is one cycle in IDLE between jobs.
- No input masking: elements beyond len pass unchanged; the engine's length_mode handles length.

Test Plan:
- Single job, requester 2, len=20, engine model latency 12 → req_ready=0100 for 1 cycle; sm_length_mode=1; one sm_valid_in pulse; resp_valid with resp_id=2, resp_len=20, resp_prob_flat equal to the model output, resp_timeout=0.
- All four req_valid held high, resp_ready tied 1 → grant order 0,1,2,3,0,1; exactly one sm_valid_in per job; no requester is starved.
- Length mapping, len = 0, 1, 16, 17, 32, 33, 64, 65, 255 → modes 2, 0, 0, 1, 1, 2, 2, 2, 2.
- Engine never responds, TIMEOUT=1023 → resp_valid exactly 1024 cycles after the sm_valid_in cycle; resp_timeout=1; prob all zero; err_count=1. Repeat 300 times → err_count saturates at 255.
- resp_ready held low 50 cycles with req_valid=1111 → resp_* stable; req_ready=0; no second sm_valid_in. After resp_ready the next grant is last_grant+1.
- rst pulse in WAIT, then sm_valid_out 3 cycles later → no resp_valid; state IDLE; outputs zero; next request from requester 0 is served normally.
